// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory arbiter slice.
package mem_arb_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Index width for a port count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requestor and RAM bus bundle for mem_arbiter.
// slave  : arbiter view (takes requests, drives the RAM).
// master : environment view (issues requests, models the RAM).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);

  localparam int GW = idx_width(NREQ);

  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      req_rdata;
  logic               ram_ren;
  logic               ram_wen;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_wdata;
  logic [DW-1:0]      ram_rdata;
  logic               ram_busy;
  logic [GW-1:0]      grant_id;

  modport slave (
    input  req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    output req_ready, req_rdata, ram_ren, ram_wen, ram_addr, ram_wdata, grant_id
  );

  modport master (
    output req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    input  req_ready, req_rdata, ram_ren, ram_wen, ram_addr, ram_wdata, grant_id
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: combinational rotating-priority picker.
// The search begins at ptr and wraps; a ptr of 0 degenerates to fixed
// lowest-index-first priority.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Walk ports starting at ptr, first requester wins.
  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < NREQ) begin
        j = int'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between NREQ requestors.
// A winner is picked in IDLE, its address/data/op are latched, and the RAM
// access is held until ram_busy drops; the winner then gets a one-cycle
// ready pulse with the load data passed straight through.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined the lowest requesting index always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int IW = idx_width(NREQ);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACCESS = ACCESS;

  logic [0:0]      state;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  op_e             op_q;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   ptr;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic            any_req;
  logic            win_rd;
  logic            done;

  assign req     = bus.req_ren | bus.req_wen;
  assign any_req = |req;
  // A port raising both enables is served as a read.
  assign win_rd  = |(bus.req_ren & grant);
  assign done    = (state == ST_ACCESS) && !bus.ram_busy;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win)
  );

`ifdef MEM_ARB_RR_EN
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
    if (int'(id) >= NREQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Rotate priority past the port just served.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (done) begin
      ptr <= next_ptr(id_q);
    end
  end
`else
  assign ptr = '0;
`endif

  // Two-state access sequencer: latch the winner in IDLE, hold in ACCESS until not busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      id_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            addr_q  <= bus.req_addr[win*AW +: AW];
            wdata_q <= bus.req_wdata[win*DW +: DW];
            op_q    <= win_rd ? OP_RD : OP_WR;
            id_q    <= win;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!bus.ram_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulse goes only to the port that owns the access.
  always_comb begin
    bus.req_ready = '0;
    if (done) bus.req_ready[id_q] = 1'b1;
  end

  assign bus.req_rdata = done ? bus.ram_rdata : '0;
  assign bus.ram_ren   = (state == ST_ACCESS) && (op_q == OP_RD);
  assign bus.ram_wen   = (state == ST_ACCESS) && (op_q == OP_WR);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.grant_id  = id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port instance for the main scenarios
// and a 4-port instance for pointer wrap. Expectations follow the build
// option MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic CLK;
  logic RST;

  int vec_cnt;
  int err_cnt;

  mem_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus_a ();
  mem_arbiter_if #(.NREQ(4), .AW(16), .DW(16)) bus_b ();

  mem_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  mem_arbiter #(.NREQ(4), .AW(16), .DW(16)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    logic [3:0]  exp_rdy4;
    logic [1:0]  exp_gid4;
    logic [15:0] exp_addr4;
    vec_cnt = 0;
    err_cnt = 0;

    RST             = 1'b1;
    bus_a.req_ren   = '0;
    bus_a.req_wen   = '0;
    bus_a.req_addr  = '0;
    bus_a.req_wdata = '0;
    bus_a.ram_rdata = '0;
    bus_a.ram_busy  = 1'b0;
    bus_b.req_ren   = '0;
    bus_b.req_wen   = '0;
    bus_b.req_addr  = '0;
    bus_b.req_wdata = '0;
    bus_b.ram_rdata = '0;
    bus_b.ram_busy  = 1'b0;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst ram_ren",   64'(bus_a.ram_ren),   64'd0);
    chk("rst ram_wen",   64'(bus_a.ram_wen),   64'd0);
    chk("rst ram_addr",  64'(bus_a.ram_addr),  64'd0);
    chk("rst ram_wdata", 64'(bus_a.ram_wdata), 64'd0);
    chk("rst ready",     64'(bus_a.req_ready), 64'd0);
    chk("rst rdata",     64'(bus_a.req_rdata), 64'd0);
    chk("rst grant_id",  64'(bus_a.grant_id),  64'd0);
    chk("rst b ready",   64'(bus_b.req_ready), 64'd0);
    next_cyc();
    RST = 1'b0;

    // 1: reset in the middle of a busy access
    bus_a.req_ren   = 2'b01;
    bus_a.req_addr  = 64'h0000_0000_0000_0100;
    bus_a.ram_busy  = 1'b1;
    bus_a.ram_rdata = 32'h0000_0055;
    next_cyc();
    bus_a.req_ren = '0;
    @(negedge CLK);
    chk("t1 ren in access", 64'(bus_a.ram_ren),   64'd1);
    chk("t1 addr latched",  64'(bus_a.ram_addr),  64'h100);
    chk("t1 ready busy",    64'(bus_a.req_ready), 64'd0);
    RST = 1'b1;
    #1;
    chk("t1 async ren",   64'(bus_a.ram_ren),  64'd0);
    chk("t1 async addr",  64'(bus_a.ram_addr), 64'd0);
    bus_a.ram_busy = 1'b0;
    @(negedge CLK);
    chk("t1 no ready in rst", 64'(bus_a.req_ready), 64'd0);
    chk("t1 rdata in rst",    64'(bus_a.req_rdata), 64'd0);
    next_cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("t1 idle ren",   64'(bus_a.ram_ren),   64'd0);
    chk("t1 idle ready", 64'(bus_a.req_ready), 64'd0);
    next_cyc();

    // 2: port 1 read, three busy cycles
    bus_a.req_ren   = 2'b10;
    bus_a.req_addr  = {32'h0000_0040, 32'h0};
    bus_a.ram_busy  = 1'b1;
    bus_a.ram_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("t2 arb cycle ren", 64'(bus_a.ram_ren), 64'd0);
    next_cyc();
    for (int c = 0; c < 4; c++) begin
      bus_a.ram_busy = (c < 3);
      @(negedge CLK);
      chk("t2 ren",   64'(bus_a.ram_ren),   64'd1);
      chk("t2 addr",  64'(bus_a.ram_addr),  64'h40);
      chk("t2 ready", 64'(bus_a.req_ready), (c == 3) ? 64'd2 : 64'd0);
      chk("t2 rdata", 64'(bus_a.req_rdata), (c == 3) ? 64'hDEAD_BEEF : 64'd0);
      next_cyc();
    end
    bus_a.req_ren = '0;
    @(negedge CLK);
    chk("t2 post ready", 64'(bus_a.req_ready), 64'd0);
    chk("t2 post ren",   64'(bus_a.ram_ren),   64'd0);
    chk("t2 grant held", 64'(bus_a.grant_id),  64'd1);
    chk("t2 addr held",  64'(bus_a.ram_addr),  64'h40);
    next_cyc();

    // 3: ren and wen together on port 0 -> read only
    bus_a.req_ren   = 2'b01;
    bus_a.req_wen   = 2'b01;
    bus_a.req_addr  = 64'h0000_0000_0000_0080;
    bus_a.req_wdata = 64'h0000_0000_0000_1234;
    bus_a.ram_busy  = 1'b0;
    bus_a.ram_rdata = 32'hCAFE_0001;
    next_cyc();
    bus_a.req_ren = '0;
    bus_a.req_wen = '0;
    @(negedge CLK);
    chk("t3 ren",      64'(bus_a.ram_ren),   64'd1);
    chk("t3 wen",      64'(bus_a.ram_wen),   64'd0);
    chk("t3 ready",    64'(bus_a.req_ready), 64'd1);
    chk("t3 rdata",    64'(bus_a.req_rdata), 64'hCAFE_0001);
    chk("t3 addr",     64'(bus_a.ram_addr),  64'h80);
    chk("t3 grant_id", 64'(bus_a.grant_id),  64'd0);
    next_cyc();
    @(negedge CLK);
    chk("t3 idle ren",   64'(bus_a.ram_ren),   64'd0);
    chk("t3 idle wen",   64'(bus_a.ram_wen),   64'd0);
    chk("t3 idle ready", 64'(bus_a.req_ready), 64'd0);
    next_cyc();

    // 5: inputs change during a write access; latched values must hold
    bus_a.req_wen   = 2'b01;
    bus_a.req_addr  = 64'h0000_0000_0000_0200;
    bus_a.req_wdata = 64'h0000_0000_A5A5_A5A5;
    bus_a.ram_busy  = 1'b1;
    next_cyc();
    bus_a.req_addr  = 64'h0000_0000_0000_0300;
    bus_a.req_wdata = 64'h0000_0000_5A5A_5A5A;
    for (int c = 0; c < 3; c++) begin
      bus_a.ram_busy = (c < 2);
      @(negedge CLK);
      chk("t5 wen",   64'(bus_a.ram_wen),   64'd1);
      chk("t5 ren",   64'(bus_a.ram_ren),   64'd0);
      chk("t5 addr",  64'(bus_a.ram_addr),  64'h200);
      chk("t5 wdata", 64'(bus_a.ram_wdata), 64'hA5A5_A5A5);
      chk("t5 ready", 64'(bus_a.req_ready), (c == 2) ? 64'd1 : 64'd0);
      next_cyc();
    end
    bus_a.req_wen = '0;

    // 4: both ports write continuously, no busy (pointer enters at port 1)
    bus_a.req_wen   = 2'b11;
    bus_a.req_addr  = {32'h0000_0014, 32'h0000_0010};
    bus_a.req_wdata = {32'h0000_0022, 32'h0000_0011};
    bus_a.ram_busy  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (c % 2 == 1) begin
`ifdef MEM_ARB_RR_EN
        exp_rdy = (((c - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp_rdy = 2'b01;
`endif
        exp_addr = (exp_rdy == 2'b10) ? 32'h14 : 32'h10;
        chk("t4 ready", 64'(bus_a.req_ready), 64'(exp_rdy));
        chk("t4 addr",  64'(bus_a.ram_addr),  64'(exp_addr));
      end else begin
        chk("t4 idle ready", 64'(bus_a.req_ready), 64'd0);
      end
      next_cyc();
    end
    bus_a.req_wen = '0;

    // 6: 4-port instance, pointer wrap from port 3 back to port 0
    bus_b.req_addr = 64'h0013_0012_0011_0010;
    bus_b.ram_busy = 1'b0;
    bus_b.req_ren  = 4'b0010;
    next_cyc();
    @(negedge CLK);
    chk("t6 p1 ready", 64'(bus_b.req_ready), 64'b0010);
    chk("t6 p1 grant", 64'(bus_b.grant_id),  64'd1);
    chk("t6 p1 addr",  64'(bus_b.ram_addr),  64'h11);
    next_cyc();
    bus_b.req_ren = 4'b1011;
    @(negedge CLK);
    chk("t6 arb ready", 64'(bus_b.req_ready), 64'd0);
    next_cyc();
`ifdef MEM_ARB_RR_EN
    exp_rdy4  = 4'b1000;
    exp_gid4  = 2'd3;
    exp_addr4 = 16'h13;
`else
    exp_rdy4  = 4'b0001;
    exp_gid4  = 2'd0;
    exp_addr4 = 16'h10;
`endif
    @(negedge CLK);
    chk("t6 second ready", 64'(bus_b.req_ready), 64'(exp_rdy4));
    chk("t6 second grant", 64'(bus_b.grant_id),  64'(exp_gid4));
    chk("t6 second addr",  64'(bus_b.ram_addr),  64'(exp_addr4));
    next_cyc();
    bus_b.req_ren = 4'b0101;
    next_cyc();
    @(negedge CLK);
    chk("t6 wrap ready", 64'(bus_b.req_ready), 64'b0001);
    chk("t6 wrap grant", 64'(bus_b.grant_id),  64'd0);
    chk("t6 wrap addr",  64'(bus_b.ram_addr),  64'h10);
    next_cyc();
    bus_b.req_ren = '0;
    repeat (2) next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
